// File: rtl/parity_check_ctrl.sv
// Even-parity frame checker with retry/drop control and error/good-frame counters.
// Latency: result (out_valid/nack/fail) 2 cycles after accept; OUT stalls on out_ready, blocking in_ready.
module parity_check_ctrl #(
  parameter int DATA_W    = 4,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              nack,
  output logic              fail,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    OUT   = 3'd2,
    NACK  = 3'd3,
    DROP  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  data_r;
  logic               parity_r;
  logic [RETRY_W-1:0] retry_cnt;
  logic               parity_err;
  logic               retry_at_max;
  logic               accept;
  logic               deliver;

  assign accept       = in_valid && (state == IDLE);
  assign deliver      = out_ready && (state == OUT);
  // Odd number of ones across payload plus parity bit means corruption.
  assign parity_err   = ^{data_r, parity_r};
  assign retry_at_max = (retry_cnt == RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (!parity_err) begin
          state_nxt = OUT;
        end else if (retry_at_max) begin
          state_nxt = DROP;
        end else begin
          state_nxt = NACK;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      NACK:    state_nxt = IDLE;
      DROP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and pulse outputs are pure state decodes, so no input reaches them combinationally.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    nack      = 1'b0;
    fail      = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      NACK:    nack      = 1'b1;
      DROP:    fail      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r   <= '0;
      parity_r <= 1'b0;
    end else if (accept) begin
      data_r   <= data_in;
      parity_r <= parity_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else if (state == CHECK && !parity_err) begin
      out_data <= data_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (state == CHECK) begin
      if (!parity_err || retry_at_max) begin
        retry_cnt <= '0;
      end else begin
        retry_cnt <= retry_cnt + 1'b1;
      end
    end
  end

  // err_count saturates; frame_count wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (state == CHECK && parity_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
    end else if (deliver) begin
      frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_check_ctrl.sv
// Bench for parity_check_ctrl: directed table, reset-in-OUT sequence, then random frames vs a reference model.
module tb_parity_check_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] data_in;
  logic       parity_in;
  logic       out_ready;
  logic       in_ready, out_valid, nack, fail;
  logic [3:0] out_data;
  logic [7:0] err_count, frame_count;
  logic       in_ready2, out_valid2, nack2, fail2;
  logic [3:0] out_data2;
  logic [1:0] err_count2, frame_count2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  parity_check_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .parity_in(parity_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .nack(nack), .fail(fail),
    .err_count(err_count), .frame_count(frame_count)
  );

  // Narrow-counter copy sharing the same stimulus, to exercise saturation and wrap.
  parity_check_ctrl #(.DATA_W(4), .MAX_RETRY(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .data_in(data_in), .parity_in(parity_in), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .nack(nack2), .fail(fail2),
    .err_count(err_count2), .frame_count(frame_count2)
  );

  typedef struct {
    logic [3:0] data;
    logic       par;
    int         hold;
    int         kind;    // 0 good, 1 nack, 2 fail
    int         err;
    int         frames;
  } vec_t;

  vec_t vecs[10];

  int m_retry, m_err, m_frames;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_counters(input int exp_err, input int exp_frames);
    check("err_count", err_count, sat(exp_err, 255));
    check("frame_count", frame_count, exp_frames % 256);
    check("err_count_w2", err_count2, sat(exp_err, 3));
    check("frame_count_w2", frame_count2, exp_frames % 4);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input int hold,
                            input int kind, input int exp_err, input int exp_frames);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", in_ready, 1);
    in_valid  = 1'b1;
    data_in   = d;
    parity_in = p;
    out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid  = 1'($urandom_range(0, 1));
    data_in   = 4'($urandom);
    parity_in = 1'($urandom);
    out_ready = 1'($urandom_range(0, 1));
    check("check_in_ready", in_ready, 0);
    check("check_quiet", {out_valid, nack, fail}, 0);
    @(negedge clk);
    check("out_valid", out_valid, kind == 0);
    check("nack", nack, kind == 1);
    check("fail", fail, kind == 2);
    check("mutex_w2", {out_valid2, nack2, fail2}, {kind == 0, kind == 1, kind == 2});
    if (kind == 0) begin
      check("out_data", out_data, d);
      for (int i = 0; i < hold; i++) begin
        out_ready = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, d);
        check("hold_in_ready", in_ready, 0);
        check("hold_frames", frame_count, (exp_frames - 1) % 256);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
    end else begin
      in_valid  = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("pulse_one_cycle", {out_valid, nack, fail}, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("back_idle", in_ready, 1);
    check_counters(exp_err, exp_frames);
  endtask

  initial begin
    int kind;
    logic [3:0] d;
    logic p;

    vecs[0] = '{4'b1010, 1'b0, 0, 0, 0, 1};
    vecs[1] = '{4'b1010, 1'b1, 0, 1, 1, 1};
    vecs[2] = '{4'b0000, 1'b0, 0, 0, 1, 2};
    vecs[3] = '{4'b0101, 1'b1, 0, 1, 2, 2};
    vecs[4] = '{4'b0101, 1'b1, 0, 1, 3, 2};
    vecs[5] = '{4'b0101, 1'b1, 0, 1, 4, 2};
    vecs[6] = '{4'b0101, 1'b1, 0, 2, 5, 2};
    vecs[7] = '{4'b0000, 1'b0, 0, 0, 5, 3};
    vecs[8] = '{4'b1010, 1'b0, 5, 0, 5, 4};
    vecs[9] = '{4'b1111, 1'b0, 1, 0, 5, 5};

    rst = 1'b1; in_valid = 1'b0; data_in = '0; parity_in = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {out_valid, nack, fail}, 0);
    check("rst_out_data", out_data, 0);
    check_counters(0, 0);

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].hold, vecs[i].kind, vecs[i].err, vecs[i].frames);
    end

    // Reset in the middle of OUT discards the frame and clears counters at once.
    in_valid = 1'b1; data_in = 4'b0110; parity_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_data", out_data, 0);
    check_counters(0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check_counters(0, 0);

    m_retry = 0; m_err = 0; m_frames = 0;
    for (int n = 0; n < 150; n++) begin
      d = 4'($urandom_range(0, 15));
      p = 1'($urandom_range(0, 1));
      if ((($countones(d) + p) % 2) == 0) begin
        kind = 0;
        m_retry = 0;
        m_frames++;
      end else begin
        m_err++;
        if (m_retry < 3) begin
          kind = 1;
          m_retry++;
        end else begin
          kind = 2;
          m_retry = 0;
        end
      end
      send_frame(d, p, $urandom_range(0, 3), kind, m_err, m_frames);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_check_ctrl.md
PARITY_CHECK_CTRL -- requirements
Module: parity_check_ctrl

Interface
REQ-001 The block SHALL take parameter DATA_W, default 4, as the data nibble width.
REQ-002 The block SHALL take parameter MAX_RETRY, default 3, as the number of consecutive retries before a frame is dropped.
REQ-003 The block SHALL take parameter CNT_W, default 8, as the width of both counters.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  upstream frame present.
REQ-008 in_ready  output  1  block can accept a frame.
REQ-009 data_in  input  DATA_W  frame payload.
REQ-010 parity_in  input  1  even-parity bit for data_in.
REQ-011 out_valid  output  1  checked good frame available.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  DATA_W  payload of the good frame.
REQ-014 nack  output  1  one-cycle pulse requesting retransmission.
REQ-015 fail  output  1  one-cycle pulse, frame dropped after MAX_RETRY retries.
REQ-016 err_count  output  CNT_W  total parity errors, saturating.
REQ-017 frame_count  output  CNT_W  total good frames delivered, wrapping.

Function
REQ-018 The FSM SHALL have states IDLE, CHECK, OUT, NACK and DROP.
REQ-019 in_ready SHALL be 1 only in IDLE; a frame is accepted on a cycle with in_valid=1 and in_ready=1, and data_in/parity_in are registered on that cycle.
REQ-020 Acceptance SHALL move IDLE->CHECK; CHECK SHALL last exactly one cycle.
REQ-021 In CHECK, error SHALL be the XOR of the registered data bits and parity bit (1 = odd total = error).
REQ-022 CHECK with no error SHALL go to OUT, clear retry_cnt and put the registered payload on out_data.
REQ-023 CHECK with error and retry_cnt < MAX_RETRY SHALL go to NACK and increment retry_cnt.
REQ-024 CHECK with error and retry_cnt == MAX_RETRY SHALL go to DROP and clear retry_cnt.
REQ-025 Every CHECK with error SHALL increment err_count, which holds at 2^CNT_W-1.
REQ-026 OUT SHALL hold out_valid=1 and a stable out_data until out_ready=1; on that cycle frame_count SHALL increment (wrapping to 0) and the FSM SHALL go to IDLE.
REQ-027 NACK and DROP SHALL each last one cycle, assert nack or fail respectively for that cycle only, then go to IDLE.
REQ-028 Latency: a good frame accepted on cycle N SHALL have out_valid=1 first at cycle N+2; a bad frame accepted on cycle N SHALL pulse nack or fail at cycle N+2.
REQ-029 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside OUT.
REQ-030 nack, fail and out_valid SHALL be mutually exclusive.
REQ-031 All outputs SHALL be registered or decoded from state only, with no combinational path from any input.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, retry_cnt=0, err_count=0, frame_count=0, out_data=0, out_valid=0, nack=0, fail=0 and in_ready=1 (after release).
REQ-033 rst asserted in any state, including mid-OUT, SHALL discard the in-flight frame without updating any counter.

Verification
REQ-034 data_in=1010, parity_in=0, out_ready=1 -> out_valid at N+2, out_data=1010, frame_count=1, err_count=0.
REQ-035 data_in=1010, parity_in=1 -> nack pulse at N+2, err_count=1, no out_valid.
REQ-036 Four consecutive bad frames (0101, parity 1) with MAX_RETRY=3 -> nack, nack, nack, then fail; err_count=4; the next good frame 0000/0 is delivered.
REQ-037 Good frame with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0; out_ready=1 -> frame_count increments once.
REQ-038 CNT_W=2, 5 bad frames -> err_count saturates at 3; CNT_W=2, 5 good frames -> frame_count=1 (wrap).
REQ-039 rst asserted during OUT -> out_valid=0 the same cycle, all counters 0, in_ready=1 after release.
